set_bit_encoder: RTL and testbench

SET_BIT_ENCODER -- requirements
Module: set_bit_encoder

---
 rtl/set_bit_encoder.sv | 108 ++++++++++
 tb/tb_set_bit_encoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_encoder.sv
// Enumerates the set-bit indices of an accepted vector, one index per output beat,
// with a popcount and an all-zero flag carried alongside every beat.
module set_bit_encoder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(WIDTH)-1:0]  out_idx,
    output logic                      out_last,
    output logic                      out_none,
    output logic [$clog2(WIDTH):0]    out_count
);

    localparam int IDXW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Handshake: a beat (or an input vector) transfers on a rising edge where valid and ready are both 1.
    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic [IDXW:0]    count_q, count_nxt, vec_pop;
    logic             none_q, none_nxt;
    logic [IDXW-1:0]  sel_idx;
    logic             single;

    always_comb begin
        vec_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            vec_pop = vec_pop + (IDXW+1)'(in_vec[i]);
        end
    end

    // Later loop iterations win, so the scan direction picks lowest or highest set bit.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending[i]) sel_idx = IDXW'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending[i]) sel_idx = IDXW'(i);
            end
        end
    end

    assign single = (pending != '0) && ((pending & (pending - ONE)) == '0);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_idx   = sel_idx;
    assign out_last  = none_q | single;
    assign out_none  = none_q;
    assign out_count = count_q;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        count_nxt   = count_q;
        none_nxt    = none_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pending_nxt = in_vec;
                    count_nxt   = vec_pop;
                    none_nxt    = (in_vec == '0);
                    state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        // Clearing everything keeps the idle outputs at zero.
                        state_nxt   = IDLE;
                        pending_nxt = '0;
                        count_nxt   = '0;
                        none_nxt    = 1'b0;
                    end else begin
                        pending_nxt = pending & ~(ONE << sel_idx);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            count_q <= '0;
            none_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            count_q <= count_nxt;
            none_q  <= none_nxt;
        end
    end

endmodule

// File: tb/tb_set_bit_encoder.sv
// Directed bench for set_bit_encoder: LSB-first and MSB-first instances share stimulus,
// each with its own expected-beat queue checked by a negedge monitor.
module tb_set_bit_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready_l, out_valid_l, out_last_l, out_none_l;
    logic [2:0] out_idx_l;
    logic [3:0] out_count_l;
    logic       in_ready_m, out_valid_m, out_last_m, out_none_m;
    logic [2:0] out_idx_m;
    logic [3:0] out_count_m;

    // Beat packing: {idx[2:0], last, none, count[3:0]}
    logic [8:0] exp_lq[$];
    logic [8:0] exp_mq[$];

    int test_cnt = 0;
    int fail_cnt = 0;
    bit last_hs  = 1'b0;

    set_bit_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l), .in_vec(in_vec),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_idx(out_idx_l),
        .out_last(out_last_l), .out_none(out_none_l), .out_count(out_count_l)
    );

    set_bit_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m), .in_vec(in_vec),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_idx(out_idx_m),
        .out_last(out_last_m), .out_none(out_none_m), .out_count(out_count_m)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [8:0] bt(input int idx, input bit last, input bit none, input int cnt);
        return {3'(idx), last, none, 4'(cnt)};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_both(input logic [8:0] l, input logic [8:0] m);
        exp_lq.push_back(l);
        exp_mq.push_back(m);
    endtask

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic wait_idle();
        int n = 0;
        while (!(in_ready_l && in_ready_m) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_wait", {7'd0, in_ready_l, in_ready_m}, 9'd3);
    endtask

    task automatic send(input logic [7:0] v);
        wait_idle();
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("first_beat_latency", {7'd0, out_valid_l, out_valid_m}, 9'd3);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (out_valid_l) begin
            if (exp_lq.size() == 0) begin
                test_cnt++; fail_cnt++;
                $display("FAIL unexpected_beat_lsb got=%h exp=none", {out_idx_l, out_last_l, out_none_l, out_count_l});
            end else begin
                check("beat_lsb", {out_idx_l, out_last_l, out_none_l, out_count_l}, exp_lq[0]);
                if (out_ready) void'(exp_lq.pop_front());
            end
        end else begin
            check("idle_zero_lsb", {out_idx_l, out_last_l, out_none_l, out_count_l}, 9'd0);
        end
        if (out_valid_m) begin
            if (exp_mq.size() == 0) begin
                test_cnt++; fail_cnt++;
                $display("FAIL unexpected_beat_msb got=%h exp=none", {out_idx_m, out_last_m, out_none_m, out_count_m});
            end else begin
                check("beat_msb", {out_idx_m, out_last_m, out_none_m, out_count_m}, exp_mq[0]);
                if (out_ready) void'(exp_mq.pop_front());
            end
        end else begin
            check("idle_zero_msb", {out_idx_m, out_last_m, out_none_m, out_count_m}, 9'd0);
        end
        if (last_hs) begin
            check("ready_after_last", {5'd0, in_ready_l, out_valid_l, in_ready_m, out_valid_m}, 9'b1010);
        end
        last_hs = rst_n && out_valid_l && out_ready && out_last_l;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        #12;
        check("reset_lsb", {in_ready_l, out_valid_l, out_idx_l, out_last_l, out_none_l, out_count_l[1:0]}, 9'b1_0000_0000);
        check("reset_count", {1'b0, out_count_l, out_count_m}, 9'd0);
        check("reset_msb", {in_ready_m, out_valid_m, out_idx_m, out_last_m, out_none_m, out_count_m[1:0]}, 9'b1_0000_0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1010_0100: lsb 2,5,7 / msb 7,5,2
        push_both(bt(2, 0, 0, 3), bt(7, 0, 0, 3));
        push_both(bt(5, 0, 0, 3), bt(5, 0, 0, 3));
        push_both(bt(7, 1, 0, 3), bt(2, 1, 0, 3));
        send(8'b1010_0100);
        wait_idle();

        // all zeros: one beat with none set
        push_both(bt(0, 1, 1, 0), bt(0, 1, 1, 0));
        send(8'h00);
        wait_idle();

        // all ones with a 3-cycle stall on the first beat
        for (int i = 0; i < 8; i++) begin
            push_both(bt(i, i == 7, 0, 8), bt(7 - i, i == 7, 0, 8));
        end
        out_ready = 1'b0;
        send(8'hFF);
        repeat (3) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();

        // in_valid held with a new vector during EMIT must wait for IDLE
        push_both(bt(0, 0, 0, 2), bt(7, 0, 0, 2));
        push_both(bt(7, 1, 0, 2), bt(0, 1, 0, 2));
        push_both(bt(1, 1, 0, 1), bt(1, 1, 0, 1));
        send(8'h81);
        in_valid = 1'b1;
        in_vec   = 8'h02;
        wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("held_vec_accepted", {7'd0, out_valid_l, out_valid_m}, 9'd3);
        wait_idle();

        // reset asserted mid-vector discards the remaining beats
        push_both(bt(2, 0, 0, 3), bt(7, 0, 0, 3));
        push_both(bt(5, 0, 0, 3), bt(5, 0, 0, 3));
        push_both(bt(7, 1, 0, 3), bt(2, 1, 0, 3));
        send(8'b1010_0100);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_vec   = 8'h10;
        #1;
        check("async_reset", {5'd0, in_ready_l, out_valid_l, in_ready_m, out_valid_m}, 9'b1010);
        exp_lq.delete();
        exp_mq.delete();
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("no_accept_in_reset", {7'd0, in_ready_l, in_ready_m}, 9'd3);

        // one-hot sweep
        for (int i = 0; i < 8; i++) begin
            push_both(bt(i, 1, 0, 1), bt(i, 1, 0, 1));
            send(8'(1 << i));
        end
        wait_idle();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("drain_lsb", 9'(exp_lq.size()), 9'd0);
        check("drain_msb", 9'(exp_mq.size()), 9'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
